// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller and its
// consumer, the vending finite_state machine.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_e;

  typedef logic [3:0] key_code_t;

  // Key codes are {col[1:0], row[1:0]} as seen by the vending FSM.
  localparam key_code_t KEY_CHIPS    = 4'h0;
  localparam key_code_t KEY_COKE     = 4'h1;
  localparam key_code_t KEY_COOKIE   = 4'h2;
  localparam key_code_t KEY_ICECREAM = 4'h3;
  localparam key_code_t KEY_COFFEE   = 4'h4;
  localparam key_code_t KEY_QTY      = 4'h6;
  localparam key_code_t KEY_CONFIRM  = 4'h7;
  localparam key_code_t KEY_COIN2    = 4'h8;
  localparam key_code_t KEY_COIN5    = 4'h9;
  localparam key_code_t KEY_COIN10   = 4'hA;
  localparam key_code_t KEY_TAKE     = 4'hB;
  localparam key_code_t KEY_START    = 4'hF;

  function automatic logic [1:0] lowestRow(input logic [3:0] rows);
    logic [1:0] idx;
    if (rows[0])      idx = 2'd0;
    else if (rows[1]) idx = 2'd1;
    else if (rows[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row pins.
// Resets to all-ones so an idle keypad reads as "nothing pressed".
module keypad_row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_i,
  output logic [3:0] rows_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= rows_i;
      sync_q <= meta_q;
    end
  end

  assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning, debouncing keypad controller delivering {col,row} events
// over valid/ack. Define KEYPAD_REPEAT_EN to enable auto-repeat while held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV     = 16'd1000,
  parameter logic [7:0]  DEBOUNCE_CNT = 8'd4,
  parameter logic [7:0]  REPEAT_DLY   = 8'd50
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] c,
  input  logic [3:0] r,
  output logic       key_valid,
  output key_code_t  key_code,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun,
  input  logic       ovr_clr
);

  if (SCAN_DIV < 16'd2) begin : g_badScanDiv
    $error("keypad_scan_ctrl: SCAN_DIV must be at least 2");
  end
  if (DEBOUNCE_CNT < 8'd1) begin : g_badDebounce
    $error("keypad_scan_ctrl: DEBOUNCE_CNT must be at least 1");
  end
  if (REPEAT_DLY < 8'd1) begin : g_badRepeat
    $error("keypad_scan_ctrl: REPEAT_DLY must be at least 1");
  end

  logic [3:0]  rowSync;
  logic [3:0]  rowsPressed;
  logic        latchedPressed;
  logic        slotEnd;

  logic [15:0] divCnt_q, divCnt_d;
  scan_state_e state_q, state_d;
  logic [1:0]  colIdx_q, colIdx_d;
  logic [1:0]  rowIdx_q, rowIdx_d;
  logic [7:0]  debCnt_q, debCnt_d;
  logic [7:0]  debNext;
  logic        emit_q, emit_d;
  logic        keyValid_q, keyValid_d;
  key_code_t   keyCode_q, keyCode_d;
  logic        overrun_q, overrun_d;
`ifdef KEYPAD_REPEAT_EN
  logic [7:0]  repCnt_q, repCnt_d;
  logic [7:0]  repNext;
`endif

  keypad_row_sync u_rowSync (
    .clk    (clk),
    .reset  (reset),
    .rows_i (r),
    .rows_o (rowSync)
  );

  assign rowsPressed    = ~rowSync;
  assign latchedPressed = rowsPressed[rowIdx_q];
  assign slotEnd        = (divCnt_q == SCAN_DIV - 16'd1);
  assign debNext        = debCnt_q + 8'd1;
`ifdef KEYPAD_REPEAT_EN
  assign repNext        = repCnt_q + 8'd1;
`endif

  assign divCnt_d = slotEnd ? 16'd0 : divCnt_q + 16'd1;

  // The column only advances when nothing is being tracked, so a key stays
  // under its own column for the whole debounce/press/release sequence.
  always_comb begin
    state_d  = state_q;
    colIdx_d = colIdx_q;
    rowIdx_d = rowIdx_q;
    debCnt_d = debCnt_q;
    emit_d   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    repCnt_d = repCnt_q;
`endif
    if (slotEnd) begin
      case (state_q)
        SCAN: begin
          if (|rowsPressed) begin
            rowIdx_d = lowestRow(rowsPressed);
            if (DEBOUNCE_CNT == 8'd1) begin
              state_d  = PRESSED;
              debCnt_d = 8'd0;
              emit_d   = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              repCnt_d = 8'd0;
`endif
            end else begin
              state_d  = DEBOUNCE;
              debCnt_d = 8'd1;
            end
          end else begin
            colIdx_d = colIdx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (latchedPressed) begin
            if (debNext == DEBOUNCE_CNT) begin
              state_d  = PRESSED;
              debCnt_d = 8'd0;
              emit_d   = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              repCnt_d = 8'd0;
`endif
            end else begin
              debCnt_d = debNext;
            end
          end else begin
            state_d  = SCAN;
            colIdx_d = colIdx_q + 2'd1;
            debCnt_d = 8'd0;
          end
        end
        PRESSED: begin
          if (latchedPressed) begin
            debCnt_d = 8'd0;
`ifdef KEYPAD_REPEAT_EN
            if (repNext == REPEAT_DLY) begin
              repCnt_d = 8'd0;
              emit_d   = 1'b1;
            end else begin
              repCnt_d = repNext;
            end
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            repCnt_d = 8'd0;
`endif
            if (debNext == DEBOUNCE_CNT) begin
              state_d  = SCAN;
              colIdx_d = colIdx_q + 2'd1;
              debCnt_d = 8'd0;
            end else begin
              debCnt_d = debNext;
            end
          end
        end
        default: begin
          state_d  = SCAN;
          debCnt_d = 8'd0;
        end
      endcase
    end
  end

  // Column and row stay frozen for at least two clocks after a confirm,
  // so the event can be built from them one cycle later.
  always_comb begin
    keyValid_d = keyValid_q;
    keyCode_d  = keyCode_q;
    overrun_d  = overrun_q;
    if (keyValid_q && key_ack) begin
      keyValid_d = 1'b0;
    end
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (emit_q) begin
      if (!keyValid_q || key_ack) begin
        keyCode_d  = {colIdx_q, rowIdx_q};
        keyValid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCnt_q   <= 16'd0;
      state_q    <= SCAN;
      colIdx_q   <= 2'd0;
      rowIdx_q   <= 2'd0;
      debCnt_q   <= 8'd0;
      emit_q     <= 1'b0;
      keyValid_q <= 1'b0;
      keyCode_q  <= KEY_CHIPS;
      overrun_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      repCnt_q   <= 8'd0;
`endif
    end else begin
      divCnt_q   <= divCnt_d;
      state_q    <= state_d;
      colIdx_q   <= colIdx_d;
      rowIdx_q   <= rowIdx_d;
      debCnt_q   <= debCnt_d;
      emit_q     <= emit_d;
      keyValid_q <= keyValid_d;
      keyCode_q  <= keyCode_d;
      overrun_q  <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      repCnt_q   <= repCnt_d;
`endif
    end
  end

  assign c         = ~(4'b0001 << colIdx_q);
  assign key_valid = keyValid_q;
  assign key_code  = keyCode_q;
  assign key_down  = (state_q == PRESSED);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad model drives the rows from
// the scanned columns and every accepted key event is matched against a queue.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] c;
  logic [3:0] r;
  logic       key_valid;
  key_code_t  key_code;
  logic       key_ack;
  logic       key_down;
  logic       overrun;
  logic       ovr_clr;

  logic       keyHeld = 1'b0;
  logic [1:0] keyCol = 2'd0;
  logic [1:0] keyRow = 2'd0;
  logic       autoAck = 1'b0;
  logic       manualAck = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int eventCount = 0;
  key_code_t expQ[$];

  keypad_scan_ctrl #(
    .SCAN_DIV     (16'd4),
    .DEBOUNCE_CNT (8'd3),
    .REPEAT_DLY   (8'd5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .c         (c),
    .r         (r),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix model: the held key pulls its row low only while its column is driven.
  assign r = (keyHeld && (c[keyCol] == 1'b0)) ? ~(4'b0001 << keyRow) : 4'hF;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCol(input logic [3:0] pat, input string tag);
    logic [3:0] prev;
    logic found;
    prev = c;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (c == pat && prev != pat) found = 1'b1;
      prev = c;
    end
    checkOutput(tag, 16'(found), 16'd1);
  endtask

  task automatic waitLevel(input int which, input logic level, input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (((which == 0) ? key_valid : key_down) == level) found = 1'b1;
    end
    checkOutput(tag, 16'(found), 16'd1);
  endtask

  // Consumer model: acks on request and pops the scoreboard on each handshake.
  initial begin
    key_ack = 1'b0;
    forever begin
      @(negedge clk);
      key_ack = key_valid && (autoAck || manualAck);
      if (key_ack) begin
        eventCount++;
        checkOutput("sb_pending", 16'(expQ.size() > 0), 16'd1);
        if (expQ.size() > 0) checkOutput("sb_code", 16'(key_code), 16'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus();
    logic [3:0] one;
    logic [3:0] expC;
    int start;
    int evBefore;
    int nExp;
    one = 4'b0001;

    reset = 1'b0;
    ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_c", 16'(c), 16'hE);
    checkOutput("rst_flags", 16'({key_valid, key_down, overrun}), 16'd0);
    checkOutput("rst_code", 16'(key_code), 16'd0);
    reset = 1'b1;

    $display("[TB] test 1: idle scan");
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      expC = ~(one << ((n / 4) % 4));
      checkOutput("scan_c", 16'(c), 16'(expC));
      checkOutput("scan_flags", 16'({key_valid, key_down}), 16'd0);
    end

    $display("[TB] test 2: press 4'h6 with ack");
    autoAck = 1'b1;
    waitCol(4'b1101, "t2_col1");
    start = cyc;
    evBefore = eventCount;
    keyCol = 2'd1;
    keyRow = 2'd2;
    expQ.push_back(KEY_QTY);
    keyHeld = 1'b1;
    waitLevel(0, 1'b1, "t2_valid");
    checkOutput("t2_latency", 16'(cyc - start), 16'd13);
    checkOutput("t2_down", 16'(key_down), 16'd1);
    keyHeld = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t2_down_held", 16'(key_down), 16'd1);
    @(negedge clk);
    checkOutput("t2_down_rel", 16'(key_down), 16'd0);
    checkOutput("t2_resume_c", 16'(c), 16'hB);
    checkOutput("t2_events", 16'(eventCount - evBefore), 16'd1);

    $display("[TB] test 3: bounce on col 0");
    waitCol(4'b1110, "t3_col0");
    evBefore = eventCount;
    keyCol = 2'd0;
    keyRow = 2'd0;
    keyHeld = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t3_frozen", 16'(c), 16'hE);
    keyHeld = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t3_advance", 16'(c), 16'hD);
    repeat (8) @(negedge clk);
    checkOutput("t3_no_valid", 16'(key_valid), 16'd0);
    checkOutput("t3_events", 16'(eventCount - evBefore), 16'd0);

    $display("[TB] test 4: overrun");
    autoAck = 1'b0;
    waitCol(4'b0111, "t4_col3");
    keyCol = 2'd3;
    keyRow = 2'd3;
    expQ.push_back(KEY_START);
    keyHeld = 1'b1;
    waitLevel(0, 1'b1, "t4_valid");
    checkOutput("t4_code", 16'(key_code), 16'hF);
    keyHeld = 1'b0;
    waitLevel(1, 1'b0, "t4_rel1");
    waitCol(4'b1110, "t4_col0");
    keyCol = 2'd0;
    keyRow = 2'd0;
    keyHeld = 1'b1;
    waitLevel(1, 1'b1, "t4_down2");
    repeat (2) @(negedge clk);
    checkOutput("t4_overrun", 16'(overrun), 16'd1);
    checkOutput("t4_code_kept", 16'(key_code), 16'hF);
    checkOutput("t4_valid_kept", 16'(key_valid), 16'd1);
    keyHeld = 1'b0;
    waitLevel(1, 1'b0, "t4_rel2");
    manualAck = 1'b1;
    repeat (2) @(negedge clk);
    manualAck = 1'b0;
    @(negedge clk);
    checkOutput("t4_acked", 16'(key_valid), 16'd0);
    checkOutput("t4_ovr_sticky", 16'(overrun), 16'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    checkOutput("t4_ovr_clr", 16'(overrun), 16'd0);

    $display("[TB] test 5: reset mid-debounce");
    autoAck = 1'b1;
    waitCol(4'b1101, "t5_col1");
    keyCol = 2'd1;
    keyRow = 2'd1;
    keyHeld = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("t5_rst_c", 16'(c), 16'hE);
    checkOutput("t5_rst_flags", 16'({key_valid, key_down, overrun}), 16'd0);
    checkOutput("t5_rst_code", 16'(key_code), 16'd0);
    repeat (3) @(negedge clk);
    expQ.push_back(4'h5);
    start = cyc;
    reset = 1'b1;
    waitLevel(0, 1'b1, "t5_valid");
    checkOutput("t5_latency", 16'(cyc - start), 16'd17);
    keyHeld = 1'b0;
    waitLevel(1, 1'b0, "t5_rel");

    $display("[TB] test 6: long hold of 4'hA");
    waitCol(4'b1011, "t6_col2");
    evBefore = eventCount;
`ifdef KEYPAD_REPEAT_EN
    nExp = 4;
`else
    nExp = 1;
`endif
    for (int i = 0; i < nExp; i++) expQ.push_back(KEY_COIN10);
    keyCol = 2'd2;
    keyRow = 2'd2;
    keyHeld = 1'b1;
    repeat (80) @(negedge clk);
    keyHeld = 1'b0;
    waitLevel(1, 1'b0, "t6_rel");
    repeat (20) @(negedge clk);
    checkOutput("t6_events", 16'(eventCount - evBefore), 16'(nExp));
  endtask

  initial begin
    applyStimulus();
    checkOutput("sb_drained", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
